// File: rtl/axi_bfm_pkg.sv
// Shared AXI response/burst encodings and FSM state types for the slave BFM.
package axi_bfm_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

  // Severity ordering matches the encoding, so the worse response is the larger value.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_slave_bfm_if.sv
// AXI4 bus bundle between the master BFM and the slave BFM.
interface axi_slave_bfm_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [1:0]            awburst;
  logic [ID_WIDTH-1:0]   awid;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [MASK_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [1:0]            arburst;
  logic [ID_WIDTH-1:0]   arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_WIDTH-1:0]   rid;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awburst, awid, awlen, awsize, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output araddr, arburst, arid, arlen, arsize, arvalid, input arready,
    input rdata, rid, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awaddr, awburst, awid, awlen, awsize, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input araddr, arburst, arid, arlen, arsize, arvalid, output arready,
    output rdata, rid, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_slave_mem.sv
// Backing store: byte-enabled write port plus a registered read port.
// A read and write to the same word on one edge returns the old contents.
module axi_slave_mem #(
  parameter int DATA_WIDTH = 512,
  parameter int MEM_DEPTH  = 1024,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [MEM_AW-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [MASK_WIDTH-1:0] i_wstrb,
  input  logic                  i_re,
  input  logic [MEM_AW-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/axi_slave_bfm.sv
// AXI4 slave responder with independent read/write FSMs over an internal memory.
// W_IDLE accept AW | W_DATA accept W beats | W_RESP present B
// R_IDLE accept AR | R_WAIT read latency countdown | R_DATA present R beats
module axi_slave_bfm
  import axi_bfm_pkg::*;
#(
  parameter int                    DATA_WIDTH = 512,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    MASK_WIDTH = DATA_WIDTH / 8,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RD_LAT     = 4
) (
  input logic              clk,
  input logic              rst,
  axi_slave_bfm_if.slave   s_axi
);
  localparam int SZ     = $clog2(MASK_WIDTH);
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH);

  // Extra MSB is the borrow: set when the address lies below BASE_ADDR.
  function automatic logic [ADDR_WIDTH:0] offs(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} - {1'b0, BASE_ADDR};
  endfunction

  wr_state_t             r_wstate;
  logic                  r_awready, r_wready, r_bvalid;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [1:0]            r_bresp, r_wresp;
  logic [7:0]            r_wlen, r_wcnt;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic                  r_wbase_ok, r_werr;

  rd_state_t             r_rstate;
  logic                  r_arready, r_rvalid, r_rlast, r_rdok;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [1:0]            r_rresp;
  logic [7:0]            r_rlen, r_rcnt;
  logic [ADDR_WIDTH-1:0] r_ridx;
  logic                  r_rbase_ok, r_rerr;
  logic [LAT_W-1:0]      r_rlat;

  logic [ADDR_WIDTH:0]   w_aw_off, w_ar_off;
  logic                  w_wbeat, w_win, w_wlast_exp, w_mem_we;
  logic [1:0]            w_beat_resp;
  logic                  w_rfetch, w_rnext_in;
  logic [ADDR_WIDTH-1:0] w_rnext_idx;
  logic [7:0]            w_rnext_cnt;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign w_aw_off    = offs(s_axi.awaddr);
  assign w_ar_off    = offs(s_axi.araddr);
  assign w_wbeat     = r_wready & s_axi.wvalid;
  assign w_win       = r_wbase_ok & (r_widx < DEPTH);
  assign w_wlast_exp = (r_wcnt == r_wlen);
  assign w_mem_we    = w_wbeat & w_win & ~r_werr;
  assign w_beat_resp = resp_max(w_win ? RESP_OKAY : RESP_DECERR,
                                (s_axi.wlast != w_wlast_exp) ? RESP_SLVERR : RESP_OKAY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate   <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bid      <= '0;
      r_bresp    <= RESP_OKAY;
      r_wresp    <= RESP_OKAY;
      r_wlen     <= '0;
      r_wcnt     <= '0;
      r_widx     <= '0;
      r_wbase_ok <= 1'b0;
      r_werr     <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_awready && s_axi.awvalid) begin
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
            r_bid      <= s_axi.awid;
            r_wlen     <= s_axi.awlen;
            r_wcnt     <= '0;
            r_widx     <= w_aw_off[ADDR_WIDTH-1:0] >> SZ;
            r_wbase_ok <= ~w_aw_off[ADDR_WIDTH];
            r_werr     <= (s_axi.awsize != 3'(SZ)) || (s_axi.awburst != BURST_INCR);
            r_wresp    <= ((s_axi.awsize != 3'(SZ)) || (s_axi.awburst != BURST_INCR))
                          ? RESP_SLVERR : RESP_OKAY;
            r_wstate   <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_wbeat) begin
            // The beat count, not wlast, decides where the burst ends.
            if (w_wlast_exp) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= resp_max(r_wresp, w_beat_resp);
              r_wstate <= W_RESP;
            end else begin
              r_wcnt  <= r_wcnt + 8'd1;
              r_widx  <= r_widx + ADDR_WIDTH'(1);
              r_wresp <= resp_max(r_wresp, w_beat_resp);
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // A fetch loads the next beat: the first after the latency, or the successor on a handshake.
  assign w_rfetch    = ((r_rstate == R_WAIT) && (r_rlat == '0)) ||
                       (r_rvalid && s_axi.rready && !r_rlast);
  assign w_rnext_idx = (r_rstate == R_DATA) ? r_ridx + ADDR_WIDTH'(1) : r_ridx;
  assign w_rnext_cnt = (r_rstate == R_DATA) ? r_rcnt + 8'd1 : 8'd0;
  assign w_rnext_in  = r_rbase_ok & (w_rnext_idx < DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate   <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rdok     <= 1'b0;
      r_rid      <= '0;
      r_rresp    <= RESP_OKAY;
      r_rlen     <= '0;
      r_rcnt     <= '0;
      r_ridx     <= '0;
      r_rbase_ok <= 1'b0;
      r_rerr     <= 1'b0;
      r_rlat     <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (r_arready && s_axi.arvalid) begin
            r_arready  <= 1'b0;
            r_rid      <= s_axi.arid;
            r_rlen     <= s_axi.arlen;
            r_ridx     <= w_ar_off[ADDR_WIDTH-1:0] >> SZ;
            r_rbase_ok <= ~w_ar_off[ADDR_WIDTH];
            r_rerr     <= (s_axi.arsize != 3'(SZ)) || (s_axi.arburst != BURST_INCR);
            r_rlat     <= LAT_W'(RD_LAT - 1);
            r_rstate   <= R_WAIT;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_WAIT: if (r_rlat != '0) r_rlat <= r_rlat - LAT_W'(1);
        R_DATA: begin
          if (r_rvalid && s_axi.rready && r_rlast) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rdok   <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
      if (w_rfetch) begin
        r_rstate <= R_DATA;
        r_rvalid <= 1'b1;
        r_ridx   <= w_rnext_idx;
        r_rcnt   <= w_rnext_cnt;
        r_rlast  <= (w_rnext_cnt == r_rlen);
        r_rresp  <= !w_rnext_in ? RESP_DECERR : (r_rerr ? RESP_SLVERR : RESP_OKAY);
        r_rdok   <= w_rnext_in & ~r_rerr;
      end
    end
  end

  axi_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .MASK_WIDTH (MASK_WIDTH),
    .MEM_AW     (MEM_AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_widx[MEM_AW-1:0]),
    .i_wdata (s_axi.wdata),
    .i_wstrb (s_axi.wstrb),
    .i_re    (w_rfetch),
    .i_raddr (w_rnext_idx[MEM_AW-1:0]),
    .o_rdata (w_mem_rdata)
  );

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bid     = r_bid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rid     = r_rid;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.rdata   = r_rdok ? w_mem_rdata : '0;
endmodule

// File: tb/tb_axi_slave_bfm.sv
// Directed self-checking bench for axi_slave_bfm with hand-computed expectations.
module tb_axi_slave_bfm;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int IW = 4;
  localparam int MW = DW / 8;
  localparam int DEPTH = 1024;
  localparam int LAT = 4;
  localparam logic [2:0] SZ = 3'd6;
  localparam logic [1:0] INCR = 2'b01;
  localparam logic [1:0] FIXED = 2'b00;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] rd_data [16];
  logic [1:0]    rd_resp [16];
  logic          rd_last [16];
  logic [IW-1:0] rd_id   [16];

  axi_slave_bfm_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi_slave_bfm #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
    .MEM_DEPTH(DEPTH), .BASE_ADDR('0), .RD_LAT(LAT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_idle();
    bus.awaddr = '0; bus.awburst = INCR; bus.awid = '0; bus.awlen = '0; bus.awsize = SZ;
    bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arburst = INCR; bus.arid = '0; bus.arlen = '0; bus.arsize = SZ;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic aw_send(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done = 0;
    bus.awaddr = addr; bus.awlen = len; bus.awid = id; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      done = (bus.awready === 1'b1);
      @(posedge clk); #1;
    end
    bus.awvalid = 1'b0;
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL aw_handshake: got no awready, required awready=1"); end
  endtask

  task automatic ar_send(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done = 0;
    bus.araddr = addr; bus.arlen = len; bus.arid = id; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      done = (bus.arready === 1'b1);
      @(posedge clk); #1;
    end
    bus.arvalid = 1'b0;
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL ar_handshake: got no arready, required arready=1"); end
  endtask

  task automatic w_beat(input logic [DW-1:0] data, input logic [MW-1:0] strb, input logic last);
    bit done = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      done = (bus.wready === 1'b1);
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL w_handshake: got no wready, required wready=1"); end
  endtask

  task automatic b_recv(output logic [1:0] resp, output logic [IW-1:0] id);
    bit done = 0;
    resp = 2'bxx; id = 'x;
    bus.bready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.bvalid === 1'b1) begin resp = bus.bresp; id = bus.bid; done = 1; end
      @(posedge clk); #1;
    end
    bus.bready = 1'b0;
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL b_wait: got no bvalid, required bvalid=1"); end
  endtask

  task automatic r_collect(input int n);
    int k = 0;
    bus.rready = 1'b1;
    for (int c = 0; c < 200 && k < n; c++) begin
      if (bus.rvalid === 1'b1) begin
        rd_data[k] = bus.rdata; rd_resp[k] = bus.rresp; rd_last[k] = bus.rlast; rd_id[k] = bus.rid;
        k++;
      end
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
    n_cmp++;
    if (k != n) begin n_err++; $display("FAIL r_wait: got %0d beats, required %0d", k, n); end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b, required 000000",
        {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast});
    end
    n_cmp++;
    if (bus.rdata !== '0 || bus.bresp !== 2'd0 || bus.rresp !== 2'd0 || bus.bid !== '0 || bus.rid !== '0) begin
      n_err++; $display("FAIL reset_data: got rdata=%0h bresp=%0d rresp=%0d, required all 0",
        bus.rdata, bus.bresp, bus.rresp);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin
      n_err++; $display("FAIL reset_release: got awready=%b arready=%b, required 1 1", bus.awready, bus.arready);
    end
  endtask

  task automatic test_write_read();
    logic [1:0] resp; logic [IW-1:0] id; int cyc = 0;
    aw_send(64'h0, 8'd3, 4'h5, SZ, INCR);
    for (int i = 0; i < 4; i++) w_beat(DW'(17 * (i + 1)), {MW{1'b1}}, i == 3);
    b_recv(resp, id);
    n_cmp++;
    if (resp !== 2'd0 || id !== 4'h5) begin
      n_err++; $display("FAIL basic_b: got bresp=%0d bid=%0h, required 0 5", resp, id);
    end
    ar_send(64'h0, 8'd3, 4'hA, SZ, INCR);
    while (bus.rvalid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    n_cmp++;
    if (cyc != LAT) begin n_err++; $display("FAIL rd_latency: got %0d cycles, required %0d", cyc, LAT); end
    r_collect(4);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_data[i] !== DW'(17 * (i + 1)) || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'd0 || rd_id[i] !== 4'hA) begin
        n_err++; $display("FAIL basic_r beat%0d: got data=%0h last=%b resp=%0d id=%0h, required %0h %b 0 a",
          i, rd_data[i], rd_last[i], rd_resp[i], rd_id[i], 17 * (i + 1), i == 3);
      end
    end
  endtask

  task automatic test_partial_strobe();
    logic [1:0] resp; logic [IW-1:0] id;
    aw_send(64'h140, 8'd0, 4'h1, SZ, INCR);
    w_beat('0, {MW{1'b1}}, 1'b1);
    b_recv(resp, id);
    aw_send(64'h140, 8'd0, 4'h1, SZ, INCR);
    w_beat({{(MW-1){8'hCC}}, 8'hAB}, MW'(1), 1'b1);
    b_recv(resp, id);
    n_cmp++;
    if (resp !== 2'd0) begin n_err++; $display("FAIL strobe_b: got bresp=%0d, required 0", resp); end
    ar_send(64'h140, 8'd0, 4'h2, SZ, INCR);
    r_collect(1);
    n_cmp++;
    if (rd_data[0] !== DW'(8'hAB) || rd_last[0] !== 1'b1) begin
      n_err++; $display("FAIL strobe_r: got data=%0h last=%b, required ab 1", rd_data[0], rd_last[0]);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [IW-1:0] id;
    ar_send(64'(DEPTH * MW), 8'd1, 4'h3, SZ, INCR);
    r_collect(2);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rd_data[i] !== '0 || rd_resp[i] !== 2'd3 || rd_last[i] !== (i == 1)) begin
        n_err++; $display("FAIL oor_r beat%0d: got data=%0h resp=%0d last=%b, required 0 3 %b",
          i, rd_data[i], rd_resp[i], rd_last[i], i == 1);
      end
    end
    aw_send(64'(DEPTH * MW), 8'd0, 4'h4, SZ, INCR);
    w_beat(DW'(32'hDEAD), {MW{1'b1}}, 1'b1);
    b_recv(resp, id);
    n_cmp++;
    if (resp !== 2'd3) begin n_err++; $display("FAIL oor_b: got bresp=%0d, required 3", resp); end
    ar_send(64'h0, 8'd0, 4'h4, SZ, INCR);
    r_collect(1);
    n_cmp++;
    if (rd_data[0] !== DW'(8'h11)) begin
      n_err++; $display("FAIL oor_mem: got word0=%0h, required 11", rd_data[0]);
    end
  endtask

  task automatic test_burst_error();
    logic [1:0] resp; logic [IW-1:0] id;
    aw_send(64'd2560, 8'd0, 4'h1, SZ, INCR);
    w_beat(DW'(8'h99), {MW{1'b1}}, 1'b1);
    b_recv(resp, id);
    aw_send(64'd2560, 8'd0, 4'h1, 3'd2, INCR);
    w_beat(DW'(8'h77), {MW{1'b1}}, 1'b1);
    b_recv(resp, id);
    n_cmp++;
    if (resp !== 2'd2) begin n_err++; $display("FAIL size_err_b: got bresp=%0d, required 2", resp); end
    ar_send(64'd2560, 8'd0, 4'h1, SZ, INCR);
    r_collect(1);
    n_cmp++;
    if (rd_data[0] !== DW'(8'h99)) begin
      n_err++; $display("FAIL size_err_mem: got %0h, required 99", rd_data[0]);
    end
    ar_send(64'h0, 8'd1, 4'h6, SZ, FIXED);
    r_collect(2);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rd_data[i] !== '0 || rd_resp[i] !== 2'd2) begin
        n_err++; $display("FAIL fixed_r beat%0d: got data=%0h resp=%0d, required 0 2", i, rd_data[i], rd_resp[i]);
      end
    end
  endtask

  task automatic test_wlast_early();
    logic [1:0] resp; logic [IW-1:0] id;
    aw_send(64'd640, 8'd3, 4'h7, SZ, INCR);
    for (int i = 0; i < 4; i++) w_beat(DW'(8'hA0 + i), {MW{1'b1}}, i == 1);
    n_cmp++;
    if (bus.wready !== 1'b0 || bus.bvalid !== 1'b1) begin
      n_err++; $display("FAIL wlast_end: got wready=%b bvalid=%b, required 0 1", bus.wready, bus.bvalid);
    end
    b_recv(resp, id);
    n_cmp++;
    if (resp !== 2'd2 || id !== 4'h7) begin
      n_err++; $display("FAIL wlast_b: got bresp=%0d bid=%0h, required 2 7", resp, id);
    end
    ar_send(64'd832, 8'd0, 4'h7, SZ, INCR);
    r_collect(1);
    n_cmp++;
    if (rd_data[0] !== DW'(8'hA3)) begin
      n_err++; $display("FAIL wlast_mem: got %0h, required a3", rd_data[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; logic [IW-1:0] id; int beat = 0; int cyc = 0;
    ar_send(64'h0, 8'd3, 4'h3, SZ, INCR);
    while (bus.rvalid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    for (int c = 0; c < 40 && beat < 4; c++) begin
      bus.rready = !(c == 1 || c == 2);
      n_cmp++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== DW'(17 * (beat + 1)) || bus.rlast !== (beat == 3) || bus.rresp !== 2'd0) begin
        n_err++; $display("FAIL bp_r c%0d: got valid=%b data=%0h last=%b, required 1 %0h %b",
          c, bus.rvalid, bus.rdata, bus.rlast, 17 * (beat + 1), beat == 3);
      end
      if (bus.rready) beat++;
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
    n_cmp++;
    if (beat != 4 || bus.rvalid !== 1'b0) begin
      n_err++; $display("FAIL bp_r_end: got beats=%0d rvalid=%b, required 4 0", beat, bus.rvalid);
    end
    aw_send(64'd1280, 8'd0, 4'h6, SZ, INCR);
    w_beat(DW'(8'h5A), {MW{1'b1}}, 1'b1);
    bus.awaddr = 64'd1344; bus.awlen = 8'd0; bus.awid = 4'h7; bus.awvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (bus.bvalid !== 1'b1 || bus.bid !== 4'h6 || bus.awready !== 1'b0) begin
        n_err++; $display("FAIL bp_b c%0d: got bvalid=%b bid=%0h awready=%b, required 1 6 0",
          c, bus.bvalid, bus.bid, bus.awready);
      end
      @(posedge clk); #1;
    end
    bus.awvalid = 1'b0;
    b_recv(resp, id);
    aw_send(64'd1344, 8'd0, 4'h7, SZ, INCR);
    w_beat(DW'(8'h5B), {MW{1'b1}}, 1'b1);
    b_recv(resp, id);
    n_cmp++;
    if (resp !== 2'd0 || id !== 4'h7) begin
      n_err++; $display("FAIL bp_next_b: got bresp=%0d bid=%0h, required 0 7", resp, id);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [IW-1:0] id;
    ar_send(64'h0, 8'd7, 4'h2, SZ, INCR);
    aw_send(64'd1920, 8'd7, 4'h9, SZ, INCR);
    w_beat(DW'(8'hE0), {MW{1'b1}}, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    bus.wdata = DW'(8'hE1); bus.wstrb = {MW{1'b1}}; bus.wvalid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0 || bus.rdata !== '0) begin
      n_err++; $display("FAIL mid_reset: got aw=%b w=%b b=%b ar=%b r=%b rdata=%0h, required all 0",
        bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rdata);
    end
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin
      n_err++; $display("FAIL mid_release: got awready=%b arready=%b, required 1 1", bus.awready, bus.arready);
    end
    aw_send(64'd1920, 8'd1, 4'h3, SZ, INCR);
    w_beat(DW'(8'h55), {MW{1'b1}}, 1'b0);
    w_beat(DW'(8'h66), {MW{1'b1}}, 1'b1);
    b_recv(resp, id);
    n_cmp++;
    if (resp !== 2'd0 || id !== 4'h3) begin
      n_err++; $display("FAIL fresh_b: got bresp=%0d bid=%0h, required 0 3", resp, id);
    end
    ar_send(64'd1920, 8'd1, 4'h4, SZ, INCR);
    r_collect(2);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rd_data[i] !== DW'(8'h55 + 17 * i) || rd_last[i] !== (i == 1) || rd_resp[i] !== 2'd0 || rd_id[i] !== 4'h4) begin
        n_err++; $display("FAIL fresh_r beat%0d: got data=%0h last=%b resp=%0d id=%0h, required %0h %b 0 4",
          i, rd_data[i], rd_last[i], rd_resp[i], rd_id[i], 8'h55 + 17 * i, i == 1);
      end
    end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_out_of_range();
    test_burst_error();
    test_wlast_early();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
